// File: rtl/ring_req_multi_if.sv
// Tester-facing bundle for the token-ring request benchmark: tester actions in,
// status flags, token position and round count out.
interface ring_req_multi_if #(
  parameter int N  = 4,
  parameter int TW = 2,
  parameter int RW = 2
);
  logic [N-1:0]  loss;
  logic          restart;
  logic          controllable_stable;
  logic          error;
  logic          objective;
  logic [TW-1:0] token;
  logic [RW-1:0] round;

  // Tester side: drives actions, observes status
  modport master (
    output loss, restart, controllable_stable,
    input  error, objective, token, round
  );

  // Ring side: consumes actions, reports status
  modport slave (
    input  loss, restart, controllable_stable,
    output error, objective, token, round
  );
endinterface

// File: rtl/ring_req_multi.sv
// N-node token ring: the token holder counts its progress to K-1, then hands the
// token on; a full lap bumps the round count, which freezes the ring at ROUNDS.
module ring_req_multi #(
  parameter int K      = 8,
  parameter int N      = 4,
  parameter int ROUNDS = 2,
  parameter int MODE   = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  ring_req_multi_if.slave bus
);
  localparam int CW = $clog2(K);
  localparam int TW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = $clog2(ROUNDS + 1);

  // One action per cycle, chosen in priority order
  typedef enum logic [2:0] {
    ACT_INIT,
    ACT_RESTART,
    ACT_HOLD,
    ACT_ADVANCE,
    ACT_PASS,
    ACT_WRAP
  } act_e;

  logic [N-1:0][CW-1:0] prg_q, prg_d;
  logic [N-1:0]         stable_q, stable_d;
  logic [TW-1:0]        token_q, token_d;
  logic [RW-1:0]        round_q, round_d;
  logic                 first_q, first_d;

  logic [N-1:0]  tok_sel_s;
  logic          loss_tok_s;
  logic [CW-1:0] prg_tok_s;
  logic          frozen_s;
  logic          done_tok_s;
  logic          last_step_s;
  logic          stable_set_s;
  logic          error_s;
  act_e          act_s;

  // Decode the token holder and gather its loss bit and progress count
  always_comb begin
    tok_sel_s  = '0;
    loss_tok_s = 1'b0;
    prg_tok_s  = '0;
    for (int i = 0; i < N; i++) begin
      tok_sel_s[i] = (token_q == TW'(i));
      loss_tok_s   = loss_tok_s | (bus.loss[i] & tok_sel_s[i]);
      prg_tok_s    = prg_tok_s | (prg_q[i] & {CW{tok_sel_s[i]}});
    end
    frozen_s     = (round_q == RW'(ROUNDS));
    done_tok_s   = (prg_tok_s == CW'(K - 1));
    last_step_s  = (prg_tok_s == CW'(K - 2));
    stable_set_s = (MODE == 0) ? 1'b1 : bus.controllable_stable;
  end

  // Pick the cycle's action: init > restart > frozen > loss > advance > pass/wrap
  always_comb begin
    act_s = ACT_HOLD;
    if (first_q) begin
      act_s = ACT_INIT;
    end else if (bus.restart) begin
      act_s = ACT_RESTART;
    end else if (frozen_s) begin
      act_s = ACT_HOLD;
    end else if (loss_tok_s) begin
      act_s = ACT_HOLD;
    end else if (!done_tok_s) begin
      act_s = ACT_ADVANCE;
    end else if (token_q != TW'(N - 1)) begin
      act_s = ACT_PASS;
    end else begin
      act_s = ACT_WRAP;
    end
  end

  // Next-state computation for the chosen action
  always_comb begin
    prg_d    = prg_q;
    stable_d = stable_q;
    token_d  = token_q;
    round_d  = round_q;
    first_d  = 1'b0;
    case (act_s)
      ACT_INIT: begin
        first_d = 1'b0;
      end
      ACT_RESTART: begin
        prg_d    = '0;
        stable_d = '0;
        token_d  = '0;
        round_d  = '0;
      end
      ACT_HOLD: begin
        first_d = 1'b0;
      end
      ACT_ADVANCE: begin
        // Only the holder moves; its stable bit is decided on the final step
        for (int i = 0; i < N; i++) begin
          prg_d[i]    = tok_sel_s[i] ? (prg_q[i] + CW'(1)) : prg_q[i];
          stable_d[i] = (tok_sel_s[i] && last_step_s) ? stable_set_s : stable_q[i];
        end
      end
      ACT_PASS: begin
        token_d = token_q + TW'(1);
      end
      ACT_WRAP: begin
        // Lap complete: back to node 0 with a clean ring
        token_d  = '0;
        round_d  = round_q + RW'(1);
        prg_d    = '0;
        stable_d = '0;
      end
      default: begin
        first_d = 1'b0;
      end
    endcase
  end

  // State register with asynchronous clear into the init cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prg_q    <= '0;
      stable_q <= '0;
      token_q  <= '0;
      round_q  <= '0;
      first_q  <= 1'b1;
    end else begin
      prg_q    <= prg_d;
      stable_q <= stable_d;
      token_q  <= token_d;
      round_q  <= round_d;
      first_q  <= first_d;
    end
  end

  // Flag any finished node whose stable bit was never set
  always_comb begin
    error_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      error_s = error_s | ((prg_q[i] == CW'(K - 1)) & ~stable_q[i]);
    end
  end

  assign bus.error     = error_s;
  assign bus.objective = frozen_s;
  assign bus.token     = token_q;
  assign bus.round     = round_q;
endmodule
